// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator datapath ALU: opcode type, opcode
// constants and the default operand width.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_OR  = 3'b011;
    localparam alu_op_t ALU_XOR = 3'b100;
    localparam alu_op_t ALU_NOT = 3'b101;
    localparam alu_op_t ALU_SHL = 3'b110;
    localparam alu_op_t ALU_SHR = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH+1-bit adder/subtractor. The extra bit is the carry for
// addition and the borrow (x < y unsigned) for subtraction.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cb_o
);

    logic [WIDTH:0] wide;

    // Zero-extended difference goes negative exactly when x < y, setting bit WIDTH.
    always_comb begin
        if (sub_i) begin
            wide = {1'b0, x_i} - {1'b0, y_i};
        end else begin
            wide = {1'b0, x_i} + {1'b0, y_i};
        end
    end

    assign sum_o = wide[WIDTH-1:0];
    assign cb_o  = wide[WIDTH];

endmodule

// File: rtl/alu8.sv
// Registered ALU: opcode mux, zero detect and carry mux feeding a result/flag
// register that loads every non-reset edge.
module alu8
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  alu_op_t          op_i,
    output logic [WIDTH-1:0] r_o,
    output logic             fz_o,
    output logic             fc_o
);

    logic [WIDTH-1:0] as_sum;
    logic             as_cb;

    logic [WIDTH-1:0] r_d, r_q;
    logic             fz_d, fz_q;
    logic             fc_d, fc_q;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x_i   (x_i),
        .y_i   (y_i),
        .sub_i (op_i == ALU_SUB),
        .sum_o (as_sum),
        .cb_o  (as_cb)
    );

    always_comb begin
        r_d  = '0;
        fc_d = 1'b0;
        case (op_i)
            ALU_ADD,
            ALU_SUB: begin
                r_d  = as_sum;
                fc_d = as_cb;
            end
            ALU_AND: r_d = x_i & y_i;
            ALU_OR:  r_d = x_i | y_i;
            ALU_XOR: r_d = x_i ^ y_i;
            ALU_NOT: r_d = ~x_i;
            ALU_SHL: begin
                r_d  = {x_i[WIDTH-2:0], 1'b0};
                fc_d = x_i[WIDTH-1];
            end
            ALU_SHR: begin
                r_d  = {1'b0, x_i[WIDTH-1:1]};
                fc_d = x_i[0];
            end
            default: begin
                r_d  = '0;
                fc_d = 1'b0;
            end
        endcase
        fz_d = (r_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q  <= '0;
            fz_q <= 1'b0;
            fc_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            fz_q <= fz_d;
            fc_q <= fc_d;
        end
    end

    assign r_o  = r_q;
    assign fz_o = fz_q;
    assign fc_o = fc_q;

endmodule

// File: tb/tb_alu8.sv
// Directed-vector bench for alu8 with hand-computed expected result and flags.
module tb_alu8;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x, y;
    alu_op_t    op;
    logic [7:0] r;
    logic       fz, fc;

    int total = 0;
    int bad   = 0;

    alu8 #(.WIDTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .x_i   (x),
        .y_i   (y),
        .op_i  (op),
        .r_o   (r),
        .fz_o  (fz),
        .fc_o  (fc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] er, input logic efz, input logic efc);
        total++;
        assert ({r, fz, fc} === {er, efz, efc})
        else begin
            bad++;
            $error("FAIL %s: got r=%h fz=%b fc=%b, want r=%h fz=%b fc=%b",
                   tag, r, fz, fc, er, efz, efc);
        end
        $display("chk %-12s x=%h y=%h op=%0d -> r=%h fz=%b fc=%b", tag, x, y, op, r, fz, fc);
    endtask

    // Apply inputs, take one edge, sample 1 time unit after it.
    task automatic step(input logic [7:0] xv, input logic [7:0] yv, input alu_op_t ov);
        x  = xv;
        y  = yv;
        op = ov;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        x   = 8'hFF;
        y   = 8'hFF;
        op  = ALU_ADD;
        @(posedge clk); #1;
        chk("reset1", 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("reset2", 8'h00, 1'b0, 1'b0);

        rst = 1'b0;
        step(8'h01, 8'h01, ALU_ADD); chk("add_1_1",   8'h02, 1'b0, 1'b0);
        step(8'hFF, 8'h01, ALU_ADD); chk("add_wrap",  8'h00, 1'b1, 1'b1);
        step(8'h80, 8'h80, ALU_ADD); chk("add_80_80", 8'h00, 1'b1, 1'b1);
        step(8'h05, 8'h02, ALU_SUB); chk("sub_plain", 8'h03, 1'b0, 1'b0);
        step(8'h03, 8'h03, ALU_SUB); chk("sub_equal", 8'h00, 1'b1, 1'b0);
        step(8'h01, 8'h04, ALU_SUB); chk("sub_borrow",8'hFD, 1'b0, 1'b1);
        step(8'h00, 8'h01, ALU_SUB); chk("sub_0_1",   8'hFF, 1'b0, 1'b1);
        step(8'hF0, 8'h3C, ALU_AND); chk("and",       8'h30, 1'b0, 1'b0);
        step(8'h0F, 8'h30, ALU_OR);  chk("or",        8'h3F, 1'b0, 1'b0);
        step(8'hAA, 8'hAA, ALU_XOR); chk("xor_zero",  8'h00, 1'b1, 1'b0);
        step(8'h0F, 8'h55, ALU_NOT); chk("not_0f",    8'hF0, 1'b0, 1'b0);
        step(8'hFF, 8'h00, ALU_NOT); chk("not_ff",    8'h00, 1'b1, 1'b0);
        step(8'h81, 8'h00, ALU_SHL); chk("shl_81",    8'h02, 1'b0, 1'b1);
        step(8'h40, 8'hFF, ALU_SHL); chk("shl_40",    8'h80, 1'b0, 1'b0);
        step(8'h01, 8'h00, ALU_SHR); chk("shr_01",    8'h00, 1'b1, 1'b1);
        step(8'h80, 8'hFF, ALU_SHR); chk("shr_80",    8'h40, 1'b0, 1'b0);

        // Mid-cycle input change must not reach the outputs before the edge.
        step(8'h10, 8'h20, ALU_ADD); chk("mid_base",  8'h30, 1'b0, 1'b0);
        #2;
        x  = 8'hFF;
        y  = 8'h02;
        op = ALU_ADD;
        #2;
        chk("mid_hold", 8'h30, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("mid_edge", 8'h01, 1'b0, 1'b1);

        // Reset wins over an operation that would set carry.
        rst = 1'b1;
        step(8'h01, 8'h04, ALU_SUB); chk("rst_override", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step(8'h01, 8'h04, ALU_SUB); chk("rst_release",  8'hFD, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
